lsu_mem_ctrl: RTL and testbench

- Load/store sequencer between the EX/MEM stage and the data-memory bus port.
- Accepts one request at a time and checks alignment.
- Drives a req/gnt + rvalid bus handshake, builds byte enables and replicated store data, and sign/zero-extends load data.
- Holds the pipeline busy until the access completes or errors.

---
 rtl/lsu_mem_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the EX/MEM stage and the data-memory bus port.
// Accepts one access at a time, rejects misaligned or unsupported ops, runs a
// req/gnt + rvalid handshake, builds byte enables / lane-replicated store data
// and sign/zero-extends load data. The pipeline is held busy until completion.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   req_valid/req_ready       pipeline request handshake (ready only when idle)
//   req_we/req_op             1=store/0=load; load LW,LB,LH,LHU,LBU / store SW,SB,SH
//   req_addr/req_wdata        byte address and store data
//   busy                      access in flight
//   resp_valid/resp_rdata     completion pulse and extended load result
//   misalign_err, bus_err     one-cycle error pulses
//   mem_req/mem_we/mem_addr/mem_wdata   bus request side (registered)
//   mem_gnt/mem_rvalid/mem_rdata        bus response side
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] OpLw  = 3'd0;
  localparam logic [2:0] OpLb  = 3'd1;
  localparam logic [2:0] OpLh  = 3'd2;
  localparam logic [2:0] OpLhu = 3'd3;
  localparam logic [2:0] OpLbu = 3'd4;
  localparam logic [2:0] OpSw  = 3'd0;
  localparam logic [2:0] OpSb  = 3'd1;
  localparam logic [2:0] OpSh  = 3'd2;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              merr_q, merr_d;
  logic              berr_q, berr_d;

  logic              req_legal;
  logic [3:0]        st_we;
  logic [31:0]       st_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;

  // Alignment and opcode legality of the incoming request.
  always_comb begin
    req_legal = 1'b0;
    if (req_we) begin
      case (req_op)
        OpSw:    req_legal = (req_addr[1:0] == 2'b00);
        OpSb:    req_legal = 1'b1;
        OpSh:    req_legal = !req_addr[0];
        default: req_legal = 1'b0;
      endcase
    end else begin
      case (req_op)
        OpLw:        req_legal = (req_addr[1:0] == 2'b00);
        OpLb, OpLbu: req_legal = 1'b1;
        OpLh, OpLhu: req_legal = !req_addr[0];
        default:     req_legal = 1'b0;
      endcase
    end
  end

  // Store lane steering; loads drive no enables and no data.
  always_comb begin
    st_we    = 4'b0000;
    st_wdata = 32'h0;
    if (req_we) begin
      case (req_op)
        OpSb: begin
          st_we    = 4'b0001 << req_addr[1:0];
          st_wdata = {4{req_wdata[7:0]}};
        end
        OpSh: begin
          st_we    = req_addr[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          st_we    = 4'b1111;
          st_wdata = req_wdata;
        end
      endcase
    end
  end

  // Load lane extraction and extension from the latched op and byte offset.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OpLb:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OpLbu:   ld_ext = {24'h0, ld_byte};
      OpLh:    ld_ext = {{16{ld_half[15]}}, ld_half};
      OpLhu:   ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    op_d        = op_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    merr_d      = 1'b0;
    berr_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_legal) begin
            we_d        = req_we;
            op_d        = req_op;
            off_d       = req_addr[1:0];
            mem_we_d    = st_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = st_wdata;
            state_d     = StReq;
          end else begin
            merr_d = 1'b1;
          end
        end
      end
      StReq: begin
        // rvalid is not looked at here: data can only follow a grant.
        if (mem_gnt) begin
          if (we_q) begin
            rdata_d = 32'h0;
            state_d = StDone;
          end else begin
            cnt_d   = '0;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // Data arriving on the final allowed cycle still wins over the timeout.
        if (mem_rvalid) begin
          rdata_d = ld_ext;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          rdata_d = 32'h0;
          berr_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      op_q        <= 3'd0;
      off_q       <= 2'd0;
      cnt_q       <= '0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      merr_q      <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      op_q        <= op_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      merr_q      <= merr_d;
      berr_q      <= berr_d;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign mem_req      = (state_q == StReq);
  assign resp_valid   = (state_q == StDone);
  assign resp_rdata   = rdata_q;
  assign misalign_err = merr_q;
  assign bus_err      = berr_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: transaction-level model of the access
// timeline, per-cycle compare process, directed literal pins and random traffic.
module tb_lsu_mem_ctrl;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        busy, resp_valid, misalign_err, bus_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .misalign_err(misalign_err),
    .bus_err     (bus_err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  int checks   = 0;
  int failures = 0;

  // Expected outputs for the current cycle.
  logic        chk_en = 1'b0;
  logic        exp_rdy, exp_busy, exp_mreq, exp_rv, exp_berr, exp_merr;
  logic [3:0]  exp_mwe;
  logic [31:0] exp_maddr, exp_mwdata, exp_rdata;

  // DUT values captured at notable points for literal pins.
  logic [3:0]  seen_we;
  logic [31:0] seen_maddr, seen_wdata, seen_rdata;
  logic        seen_rv, seen_berr, seen_merr, seen_mreq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("mem_req", 32'(mem_req), 32'(exp_mreq));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      chk("bus_err", 32'(bus_err), 32'(exp_berr));
      chk("misalign_err", 32'(misalign_err), 32'(exp_merr));
      chk("resp_rdata", resp_rdata, exp_rdata);
      if (exp_mreq) begin
        chk("mem_we", 32'(mem_we), 32'(exp_mwe));
        chk("mem_addr", mem_addr, exp_maddr);
        chk("mem_wdata", mem_wdata, exp_mwdata);
      end
    end
  end

  // Access size in bytes, 0 for an unsupported op.
  function automatic int unsigned acc_size(input logic we, input logic [2:0] op);
    if (we) return (op == 3'd0) ? 4 : (op == 3'd1) ? 1 : (op == 3'd2) ? 2 : 0;
    case (op)
      3'd0:       return 4;
      3'd1, 3'd4: return 1;
      3'd2, 3'd3: return 2;
      default:    return 0;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] op, input logic [31:0] a);
    int unsigned sz = acc_size(we, op);
    return (sz != 0) && ((a % sz) == 0);
  endfunction

  function automatic logic [3:0] model_we(input logic we, input logic [2:0] op,
                                          input logic [31:0] a);
    int unsigned sz = acc_size(we, op);
    logic [3:0] m;
    if (!we) return 4'b0000;
    m = (sz == 4) ? 4'hF : (sz == 2) ? 4'h3 : 4'h1;
    return m << (a % 4);
  endfunction

  function automatic logic [31:0] model_wdata(input logic we, input logic [2:0] op,
                                              input logic [31:0] d);
    int unsigned sz = acc_size(we, op);
    if (!we) return 32'h0;
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    int unsigned sz = acc_size(1'b0, op);
    logic [31:0] mask, v;
    if (sz == 4) return rd;
    mask = (sz == 1) ? 32'hFF : 32'hFFFF;
    v = (rd >> (8 * (a % 4))) & mask;
    if ((op == 3'd1 || op == 3'd2) && v > (mask >> 1)) v = v | ~mask;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic rdy, input logic bsy, input logic mreq, input logic rv,
                         input logic berr, input logic merr);
    exp_rdy  = rdy;
    exp_busy = bsy;
    exp_mreq = mreq;
    exp_rv   = rv;
    exp_berr = berr;
    exp_merr = merr;
  endtask

  // Random request traffic while the controller is busy; it must be ignored.
  task automatic junk_req();
    req_valid = 1'($urandom);
    req_we    = 1'($urandom);
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  // Runs one access starting in the current (idle) cycle.
  // gd: cycles of gnt delay; rd: WAIT cycle index of rvalid, -1 for none.
  task automatic txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input int gd, input int rd,
                     input logic [31:0] rdata);
    logic hit = 1'b0;
    logic berr = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    next_cycle();
    if (!is_legal(we, op, addr)) begin
      req_valid = 1'b0;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      seen_merr = misalign_err;
      seen_mreq = mem_req;
      return;
    end
    exp_mwe    = model_we(we, op, addr);
    exp_maddr  = addr & ~32'h3;
    exp_mwdata = model_wdata(we, op, wdata);
    for (int i = 0; i <= gd; i++) begin
      set_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      junk_req();
      mem_gnt    = (i == gd);
      mem_rvalid = 1'($urandom);
      mem_rdata  = $urandom;
      if (i == 0) begin
        @(negedge clk);
        seen_we    = mem_we;
        seen_maddr = mem_addr;
        seen_wdata = mem_wdata;
      end
      next_cycle();
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (!we) begin
      for (int i = 0; i < int'(TIMEOUT); i++) begin
        set_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        junk_req();
        mem_rvalid = (i == rd);
        mem_rdata  = (i == rd) ? rdata : $urandom;
        next_cycle();
        if (i == rd) begin
          hit = 1'b1;
          break;
        end
      end
      mem_rvalid = 1'b0;
      exp_rdata  = hit ? model_load(op, addr, rdata) : 32'h0;
      berr       = !hit;
    end else begin
      exp_rdata = 32'h0;
    end
    set_exp(1'b0, 1'b1, 1'b0, 1'b1, berr, 1'b0);
    junk_req();
    @(negedge clk);
    seen_rdata = resp_rdata;
    seen_rv    = resp_valid;
    seen_berr  = bus_err;
    next_cycle();
    req_valid = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_op     = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    exp_rdata  = 32'h0;
    exp_mwe    = 4'h0;
    exp_maddr  = 32'h0;
    exp_mwdata = 32'h0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // Stores
    txn(1'b1, 3'd0, 32'h100, 32'hDEADBEEF, 0, -1, 32'h0);
    chk("sw_we", 32'(seen_we), 32'hF);
    chk("sw_addr", seen_maddr, 32'h100);
    chk("sw_rv", 32'(seen_rv), 32'h1);
    chk("sw_rdata", seen_rdata, 32'h0);
    txn(1'b1, 3'd1, 32'h103, 32'h0000_00A5, 0, -1, 32'h0);
    chk("sb_we", 32'(seen_we), 32'h8);
    chk("sb_wdata", seen_wdata, 32'hA5A5A5A5);
    txn(1'b1, 3'd2, 32'h102, 32'h0000_1234, 0, -1, 32'h0);
    chk("sh_we", 32'(seen_we), 32'hC);
    chk("sh_wdata", seen_wdata, 32'h12341234);

    // Loads with extension
    txn(1'b0, 3'd1, 32'h201, 32'h0, 0, 0, 32'h0000_8000);
    chk("lb_data", seen_rdata, 32'hFFFFFF80);
    txn(1'b0, 3'd4, 32'h201, 32'h0, 0, 0, 32'h0000_8000);
    chk("lbu_data", seen_rdata, 32'h00000080);
    txn(1'b0, 3'd2, 32'h202, 32'h0, 0, 0, 32'h8001_0000);
    chk("lh_data", seen_rdata, 32'hFFFF8001);
    txn(1'b0, 3'd3, 32'h202, 32'h0, 0, 0, 32'h8001_0000);
    chk("lhu_data", seen_rdata, 32'h00008001);

    // Rejected requests
    txn(1'b0, 3'd0, 32'h102, 32'h0, 0, 0, 32'h0);
    chk("lw_mis_err", 32'(seen_merr), 32'h1);
    chk("lw_mis_req", 32'(seen_mreq), 32'h0);
    txn(1'b1, 3'd2, 32'h101, 32'h0, 0, 0, 32'h0);
    chk("sh_mis_err", 32'(seen_merr), 32'h1);
    txn(1'b0, 3'd5, 32'h100, 32'h0, 0, 0, 32'h0);
    chk("op5_err", 32'(seen_merr), 32'h1);
    txn(1'b1, 3'd3, 32'h100, 32'h0, 0, 0, 32'h0);
    chk("sop3_err", 32'(seen_merr), 32'h1);

    // Delayed grant, timeout, rvalid on the last allowed cycle
    txn(1'b0, 3'd0, 32'h400, 32'h0, 3, 1, 32'h11223344);
    chk("lw_gd_data", seen_rdata, 32'h11223344);
    txn(1'b0, 3'd0, 32'h404, 32'h0, 0, -1, 32'h0);
    chk("to_berr", 32'(seen_berr), 32'h1);
    chk("to_rv", 32'(seen_rv), 32'h1);
    chk("to_rdata", seen_rdata, 32'h0);
    txn(1'b0, 3'd0, 32'h408, 32'h0, 0, int'(TIMEOUT) - 1, 32'hCAFEF00D);
    chk("last_berr", 32'(seen_berr), 32'h0);
    chk("last_rdata", seen_rdata, 32'hCAFEF00D);

    // Reset while waiting for read data
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_op    = 3'd0;
    req_addr  = 32'h300;
    next_cycle();
    req_valid  = 1'b0;
    exp_mwe    = 4'h0;
    exp_maddr  = 32'h300;
    exp_mwdata = 32'h0;
    set_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0;
    set_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst        = 1'b0;
    exp_rdata  = 32'h0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555AAAA;
    @(negedge clk);
    chk("rst_wait_mreq", 32'(mem_req), 32'h0);
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("stale_rv", 32'(resp_valid), 32'h0);
    txn(1'b0, 3'd0, 32'h500, 32'h0, 1, 2, 32'h0BADF00D);
    chk("post_rst_lw", seen_rdata, 32'h0BADF00D);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      logic        we;
      logic [2:0]  op;
      logic [31:0] a;
      int          gd, rd, r;
      we = 1'($urandom);
      if ($urandom_range(0, 7) == 0) op = 3'($urandom);
      else op = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'h3;
      gd = $urandom_range(0, 3);
      r  = $urandom_range(0, 9);
      rd = (r == 0) ? -1 : (r == 1) ? int'(TIMEOUT) - 1 : $urandom_range(0, 3);
      txn(we, op, a, $urandom, gd, rd, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        next_cycle();
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    next_cycle();
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
